// File: rtl/mmio_uart_tx_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter:
// FSM state encoding, status word bit positions and a status packing helper.
package mmio_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int STATUS_W    = 16;
  localparam int BUSY_BIT    = 15;
  localparam int OVERRUN_BIT = 14;
  localparam int CLEAR_BIT   = 15;
  localparam int DATA_BITS   = 8;
  localparam int BAUD_CNT_W  = 16;

  // Status word layout: busy, overrun, six reserved zero bits, last accepted byte.
  function automatic logic [STATUS_W-1:0] pack_status(
    input logic                 busy,
    input logic                 overrun,
    input logic [DATA_BITS-1:0] data
  );
    logic [STATUS_W-1:0] word;
    word              = '0;
    word[BUSY_BIT]    = busy;
    word[OVERRUN_BIT] = overrun;
    word[7:0]         = data;
    return word;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// IO-slot bundle between the CPU memory map and the UART transmitter:
// write strobe and data in, status word and serial line out.
interface mmio_uart_tx_if;
  import mmio_uart_tx_pkg::*;

  logic                load;
  logic [STATUS_W-1:0] in;
  logic [STATUS_W-1:0] out;
  logic                tx;

  modport master (
    output load,
    output in,
    input  out,
    input  tx
  );

  modport slave (
    input  load,
    input  in,
    output out,
    output tx
  );

endinterface

// File: rtl/mmio_uart_tx_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last
// cycle of each bit period; held at zero whenever disabled.
module uart_baud_counter
  import mmio_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic bit_done_o
);

  localparam logic [BAUD_CNT_W-1:0] LAST_CNT = BAUD_CNT_W'(CLKS_PER_BIT - 1);

  logic [BAUD_CNT_W-1:0] cnt_q;
  logic [BAUD_CNT_W-1:0] cnt_d;
  logic                  at_last_s;

  // Next count: wrap on the last cycle of a bit, clear when disabled.
  always_comb begin
    at_last_s = (cnt_q == LAST_CNT);
    cnt_d     = cnt_q;
    if (!en_i) begin
      cnt_d = {BAUD_CNT_W{1'b0}};
    end else if (at_last_s) begin
      cnt_d = {BAUD_CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + {{(BAUD_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {BAUD_CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_done_o = en_i & at_last_s;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: a non-clear write while idle starts a
// frame, writes while busy are dropped and flag a sticky overrun.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic          clk,
  input  logic          rst_n,
  mmio_uart_tx_if.slave bus
);

  tx_state_e                state_q;
  logic                     tx_q;
  logic                     busy_q;
  logic                     ovr_q;
  logic                     ovr_d;
  logic [DATA_BITS-1:0]     data_q;
  logic [DATA_BITS-1:0]     shift_q;
  logic [2:0]               bit_idx_q;

  logic                     wr_data_s;
  logic                     wr_clear_s;
  logic                     wr_start_s;
  logic                     wr_drop_s;
  logic                     baud_en_s;
  logic                     bit_done_s;
  logic                     unused_in_s;

  // Reserved write-data bits carry no meaning for this slot.
  assign unused_in_s = ^bus.in[14:8];

  // Decode the write strobe against the current state and update overrun.
  always_comb begin
    wr_data_s  = bus.load & ~bus.in[CLEAR_BIT];
    wr_clear_s = bus.load &  bus.in[CLEAR_BIT];
    wr_start_s = wr_data_s & (state_q == IDLE);
    wr_drop_s  = wr_data_s & (state_q != IDLE);
    baud_en_s  = (state_q != IDLE);
    if (wr_clear_s) begin
      ovr_d = 1'b0;
    end else if (wr_drop_s) begin
      ovr_d = 1'b1;
    end else begin
      ovr_d = ovr_q;
    end
  end

  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (baud_en_s),
    .bit_done_o (bit_done_s)
  );

  // Frame FSM with registered line and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
      data_q    <= 8'h00;
      shift_q   <= 8'h00;
      bit_idx_q <= 3'd0;
    end else begin
      ovr_q <= ovr_d;
      case (state_q)
        IDLE: begin
          if (wr_start_s) begin
            state_q   <= START;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            data_q    <= bus.in[7:0];
            shift_q   <= bus.in[7:0];
            bit_idx_q <= 3'd0;
          end else begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        START: begin
          if (bit_done_s) begin
            state_q   <= DATA;
            tx_q      <= shift_q[0];
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_idx_q <= 3'd0;
          end else begin
            tx_q <= 1'b0;
          end
        end
        DATA: begin
          if (bit_done_s) begin
            if (bit_idx_q == 3'd7) begin
              state_q   <= STOP;
              tx_q      <= 1'b1;
              bit_idx_q <= 3'd0;
            end else begin
              tx_q      <= shift_q[0];
              shift_q   <= {1'b0, shift_q[7:1]};
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            bit_idx_q <= bit_idx_q;
          end
        end
        STOP: begin
          // Busy stays up through the last stop cycle so a write there is dropped.
          if (bit_done_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            tx_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          tx_q      <= 1'b1;
          busy_q    <= 1'b0;
          bit_idx_q <= 3'd0;
        end
      endcase
    end
  end

  assign bus.tx  = tx_q;
  assign bus.out = pack_status(busy_q, ovr_q, data_q);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized bench for mmio_uart_tx: a timing-based reference model predicts
// status and frames; a line monitor decodes tx and checks against a queue.
module tb_mmio_uart_tx;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(.CLKS_PER_BIT(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int        n_vec = 0;
  int        n_err = 0;
  longint    edge_cnt = 0;

  // Reference model: acceptance edge of the current/last frame, overrun, data.
  longint    last_acc = -1000000;
  logic      ovr_m = 1'b0;
  logic [7:0] data_m = 8'h00;
  logic [7:0] exp_q[$];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_status(input longint e);
    logic busy;
    busy = (e >= last_acc) && (e < last_acc + 10 * N);
    return {busy, ovr_m, 6'b000000, data_m};
  endfunction

  task automatic model_reset();
    last_acc = -1000000;
    ovr_m    = 1'b0;
    data_m   = 8'h00;
    exp_q.delete();
  endtask

  // A frame is accepted when the previous one ended at least one edge earlier.
  task automatic do_write(input logic [15:0] v);
    longint k;
    k = edge_cnt + 1;
    bus.load = 1'b1;
    bus.in   = v;
    @(posedge clk);
    if (v[15]) begin
      ovr_m = 1'b0;
    end else if (k > last_acc + 10 * N) begin
      last_acc = k;
      data_m   = v[7:0];
      exp_q.push_back(v[7:0]);
    end else begin
      ovr_m = 1'b1;
    end
    #1;
    bus.load = 1'b0;
    bus.in   = 16'h0000;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Status word compared every cycle against the model.
  always @(negedge clk) begin
    check16("status", bus.out, model_status(edge_cnt));
  end

  // Line monitor: decodes 8N1 frames, checking every cycle of every bit.
  bit         mon_on = 1'b0;
  bit         mon_ok = 1'b1;
  int         mon_pos = 0;
  logic [7:0] mon_byte = 8'h00;

  always @(negedge clk) begin
    int b;
    int off;
    logic [7:0] exp_b;
    if (!rst_n) begin
      mon_on = 1'b0;
    end else begin
      if (!mon_on && bus.tx == 1'b0) begin
        mon_on   = 1'b1;
        mon_ok   = 1'b1;
        mon_pos  = 0;
        mon_byte = 8'h00;
      end
      if (mon_on) begin
        b   = mon_pos / N;
        off = mon_pos % N;
        if (b == 0) begin
          if (bus.tx !== 1'b0) mon_ok = 1'b0;
        end else if (b <= 8) begin
          if (off == 0) mon_byte[b-1] = bus.tx;
          else if (bus.tx !== mon_byte[b-1]) mon_ok = 1'b0;
        end else begin
          if (bus.tx !== 1'b1) mon_ok = 1'b0;
        end
        if (mon_pos == 10 * N - 1) begin
          mon_on = 1'b0;
          if (exp_q.size() == 0) begin
            check16("unexpected_frame", {7'd0, mon_ok, mon_byte}, 16'hFFFF);
          end else begin
            exp_b = exp_q.pop_front();
            check16("frame", {7'd0, mon_ok, mon_byte}, {7'd0, 1'b1, exp_b});
          end
        end else begin
          mon_pos++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    bus.load = 1'b0;
    bus.in   = 16'h0000;
    rst_n    = 1'b0;
    model_reset();
    idle(3);
    check16("reset_tx", {15'd0, bus.tx}, 16'h0001);
    check16("reset_out", bus.out, 16'h0000);
    rst_n = 1'b1;

    // Plain frame, first write on the first edge out of reset.
    do_write(16'h0055);
    idle(45);
    check16("after_55", bus.out, 16'h0055);

    // Overrun while busy, then clear while idle.
    do_write(16'h00A3);
    idle(9);
    do_write(16'h00FF);
    idle(3);
    check16("during_A3", bus.out, 16'hC0A3);
    idle(40);
    check16("after_A3", bus.out, 16'h40A3);
    do_write(16'h8000);
    idle(5);
    check16("cleared", bus.out, 16'h00A3);
    check16("idle_tx", {15'd0, bus.tx}, 16'h0001);

    // Write on the stop-completion edge is dropped; the next edge is accepted.
    do_write(16'h0011);
    idle(39);
    do_write(16'h0022);
    do_write(16'h0001);
    do_write(16'h8000);
    idle(45);

    // Asynchronous reset in the middle of the data bits.
    do_write(16'h005A);
    idle(15);
    rst_n = 1'b0;
    model_reset();
    #1;
    check16("async_rst_tx", {15'd0, bus.tx}, 16'h0001);
    check16("async_rst_out", bus.out, 16'h0000);
    idle(3);
    rst_n = 1'b1;
    do_write(16'h00C3);
    idle(45);

    // Randomized writes and clears.
    for (int i = 0; i < 80; i++) begin
      idle($urandom_range(0, 45));
      if ($urandom_range(0, 9) < 7) v = {1'b0, 7'($urandom), 8'($urandom)};
      else v = {1'b1, 15'($urandom)};
      do_write(v);
    end

    idle(50);
    check16("queue_drain", 16'(exp_q.size()), 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 217, meaning clk cycles per UART bit (25 MHz / 115200 baud); legal range 2..65535.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 The block SHALL have port load, input, 1, write strobe from one memory-map IO slot select line.
REQ-005 The block SHALL have port in, input, 16, CPU write data, sampled only when load=1.
REQ-006 The block SHALL have port out, output, 16, status word returned on that IO slot's read-data input.
REQ-007 The block SHALL have port tx, output, 1, serial line, idle high.

Function
REQ-008 Frame SHALL be 8N1: start bit 0, data bits in[7:0] LSB first, one stop bit 1; each bit held exactly CLKS_PER_BIT cycles.
REQ-009 FSM states SHALL be IDLE, START, DATA, STOP; IDLE->START on accepted write; START->DATA after CLKS_PER_BIT cycles; DATA->STOP after 8 bits; STOP->IDLE after CLKS_PER_BIT cycles.
REQ-010 A write SHALL be accepted when load=1, in[15]=0 and state=IDLE: in[7:0] latched, tx driven low from the next cycle.
REQ-011 tx SHALL be registered; latency from accepting edge to tx falling SHALL be 1 cycle; frame length SHALL be 10*CLKS_PER_BIT cycles.
REQ-012 out[15] (busy) SHALL be 1 in every state except IDLE, rising the cycle after acceptance and falling on the cycle tx returns to IDLE after the stop bit.
REQ-013 A write with load=1, in[15]=0 while busy SHALL be dropped (data and frame unaffected) and SHALL set out[14] (overrun, sticky).
REQ-014 A write with load=1, in[15]=1 SHALL clear overrun and SHALL NOT start a frame, in any state.
REQ-015 If an overrun-causing write and a clear write cannot coincide (single load), no priority rule SHALL be needed; a clear in the same cycle the frame ends SHALL only clear.
REQ-016 out[7:0] SHALL hold the last accepted byte; out[13:8] SHALL read 0.
REQ-017 A write on the exact cycle STOP completes (busy still 1) SHALL be treated as busy: dropped, overrun set; next cycle is IDLE.
REQ-018 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap; bit index SHALL count 0..7; no other counter wrap permitted.

Reset
REQ-019 On rst_n=0 (asynchronous) the block SHALL enter IDLE with tx=1, out=16'h0000, counters 0, within the same cycle, aborting any frame in progress.
REQ-020 Reset deassertion SHALL be synchronous to clk at the instantiating level; the first write SHALL be accepted on the first clk edge with rst_n=1.

Structure
REQ-021 A shared package SHALL hold the state enum (IDLE, START, DATA, STOP) and status bit positions (BUSY=15, OVERRUN=14, CLEAR=15).
REQ-022 Sub-module uart_baud_counter SHALL generate a one-cycle bit_done pulse every CLKS_PER_BIT cycles while enabled, resetting to 0 when disabled.
REQ-023 All outputs SHALL be driven by registers; no combinational path from load/in to tx.

Verification (CLKS_PER_BIT=4)
REQ-024 Write 16'h0055 from idle -> tx low 1 cycle later, sequence 0,1,0,1,0,1,0,1,0,1 each 4 cycles, busy=1 for 40 cycles, out=16'h0055 after.
REQ-025 Write 16'h00A3, write 16'h00FF 10 cycles later -> frame carries only 8'hA3, out=16'hC0A3 during frame, 16'h40A3 after.
REQ-026 Write 16'h8000 after overrun -> out[14]=0, tx stays high, busy stays 0.
REQ-027 Assert rst_n=0 mid-DATA -> tx=1 and out=16'h0000 immediately, no clk edge required; write after release transmits normally.
REQ-028 Write 16'h0001 at the cycle busy falls -> accepted, new start bit directly after stop bit, no idle gap beyond 1 cycle.
